// File: rtl/dmem_pkg.sv
// dmem_pkg: shared geometry, FSM states and line-index helper for the data memory model.
package dmem_pkg;
    localparam int LINE_W      = 256;
    localparam int DEPTH       = 512;
    localparam int IDX_W       = $clog2(DEPTH);
    localparam int LATENCY_DEF = 10;

    typedef enum logic {IDLE, WAIT} state_t;

    // Byte offset within a line is dropped; bits above the array size alias.
    function automatic logic [IDX_W-1:0] line_idx(input logic [31:0] addr);
        return addr[IDX_W+4:5];
    endfunction
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: whole-line request/ack bus between the cache controller and main memory.
interface data_memory_if;
    import dmem_pkg::*;
    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    modport master (output addr_i, data_i, enable_i, write_i, input ack_o, data_o);
    modport slave  (input addr_i, data_i, enable_i, write_i, output ack_o, data_o);
endinterface

// File: rtl/data_memory.sv
// data_memory: 16 KB main-memory model serving one whole-line read or write per request
// after a fixed latency, acknowledged by a single-cycle pulse.
module data_memory
    import dmem_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input logic           clk_i,
    input logic           rst_i,
    data_memory_if.slave  bus
);
    localparam int CNT_W = $clog2(LATENCY);

    logic [LINE_W-1:0] memory [0:DEPTH-1];
    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  idx;
    logic              ack;
    logic              unused_addr;

    assign idx         = line_idx(bus.addr_i);
    assign unused_addr = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};
    assign ack         = state == WAIT && count == CNT_W'(LATENCY - 1);
    assign bus.ack_o   = ack;
    assign bus.data_o  = ack ? memory[idx] : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            count <= '0;
        end else if (state == IDLE) begin
            state <= bus.enable_i ? WAIT : IDLE;
            count <= '0;
        end else begin
            state <= ack ? IDLE : WAIT;
            count <= ack ? '0 : count + 1'b1;
        end
    end

    // No reset on the array so the bench can preload it; reset kills ack, which drops any pending write.
    always_ff @(posedge clk_i) begin
        if (ack && bus.write_i) memory[idx] <= bus.data_i;
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed checks of latency, read/write, aliasing, reset abort, back-to-back and idle.
module tb_data_memory;
    import dmem_pkg::*;

    logic clk;
    logic rst_i;
    int   n_checks;
    int   n_fail;

    data_memory_if bus();
    data_memory dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang, want completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cyc = 1 in the cycle right after the acceptance edge; returns the cycle ack was seen in.
    task automatic run(input logic [31:0] a, input logic [255:0] d, input logic w,
                       output int cyc, output logic [255:0] rd);
        bus.addr_i   = a;
        bus.data_i   = d;
        bus.write_i  = w;
        bus.enable_i = 1'b1;
        step();
        cyc = 1;
        rd  = '0;
        while (!bus.ack_o && cyc < 30) begin
            step();
            cyc++;
        end
        rd = bus.data_o;
        step();
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
    endtask

    initial begin
        int            cyc;
        int            t;
        int            first;
        int            second;
        int            hits;
        logic          ack_after;
        logic [255:0]  rd;
        logic [255:0]  dsum;
        n_checks     = 0;
        n_fail       = 0;
        rst_i        = 1'b0;
        bus.addr_i   = '0;
        bus.data_i   = '0;
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        dut.memory[0]  <= 256'h5;
        dut.memory[1]  <= 256'h11;
        dut.memory[32] <= 256'h77;
        #1;
        check("rst_ack", 256'(bus.ack_o), 256'h0);
        check("rst_data", bus.data_o, 256'h0);
        step();
        step();
        rst_i = 1'b1;

        run(32'h0, '0, 1'b0, cyc, rd);
        check("rd_latency", 256'(cyc), 256'd10);
        check("rd_data", rd, 256'h5);
        check("rd_ack_low_after", 256'(bus.ack_o), 256'h0);

        run(32'h400, 256'hDEAD_BEEF, 1'b1, cyc, rd);
        check("wr_latency", 256'(cyc), 256'd10);
        check("wr_ack_data_old", rd, 256'h77);
        check("wr_commit", dut.memory[32], 256'hDEAD_BEEF);

        run(32'h400, '0, 1'b0, cyc, rd);
        check("rd_back", rd, 256'hDEAD_BEEF);
        run(32'h41F, '0, 1'b0, cyc, rd);
        check("rd_offset", rd, 256'hDEAD_BEEF);
        run(32'h4400, '0, 1'b0, cyc, rd);
        check("rd_alias", rd, 256'hDEAD_BEEF);

        bus.addr_i   = 32'h20;
        bus.data_i   = 256'hBAD;
        bus.write_i  = 1'b1;
        bus.enable_i = 1'b1;
        step();
        repeat (4) step();
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        rst_i = 1'b0;
        #1;
        check("midrst_ack", 256'(bus.ack_o), 256'h0);
        check("midrst_data", bus.data_o, 256'h0);
        check("midrst_state", 256'(dut.state), 256'(IDLE));
        repeat (3) step();
        rst_i = 1'b1;
        repeat (12) step();
        check("midrst_mem", dut.memory[1], 256'h11);
        run(32'h20, '0, 1'b0, cyc, rd);
        check("postrst_latency", 256'(cyc), 256'd10);
        check("postrst_data", rd, 256'h11);

        bus.addr_i   = 32'h0;
        bus.write_i  = 1'b0;
        bus.enable_i = 1'b1;
        t         = 0;
        first     = 0;
        second    = 0;
        ack_after = 1'b0;
        while (second == 0 && t < 60) begin
            step();
            t++;
            if (first != 0 && t == first + 1) ack_after = bus.ack_o;
            if (bus.ack_o) begin
                if (first == 0) first = t;
                else second = t;
            end
        end
        step();
        bus.enable_i = 1'b0;
        check("b2b_first", 256'(first), 256'd10);
        check("b2b_gap", 256'(second - first), 256'd11);
        check("b2b_ack_single", 256'(ack_after), 256'h0);

        bus.addr_i  = 32'h0;
        bus.data_i  = 256'hFFFF;
        bus.write_i = 1'b1;
        hits = 0;
        dsum = '0;
        repeat (20) begin
            step();
            hits += int'(bus.ack_o);
            dsum |= bus.data_o;
        end
        bus.write_i = 1'b0;
        check("idle_ack", 256'(hits), 256'h0);
        check("idle_data", dsum, 256'h0);
        check("idle_mem", dut.memory[0], 256'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
